mem_stage_sram_ctrl: RTL and testbench

//  Responder for the mem_read/mem_write requests that decode raises for LDR/STR and the MEM stage carries.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 16 +
 rtl/mem_stage_sram_ctrl_sram_wait_counter.sv | 34 +++
 rtl/mem_stage_sram_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding and defaults.
package mem_stage_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int          SRAM_DQ_W           = 16;
    localparam int          CNT_W               = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
    localparam int          DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_stage_sram_ctrl_sram_wait_counter.sv
// Wait-state down-counter: loaded at the start of each half access, expires at zero.
module sram_wait_counter
    import mem_stage_sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Maps 32-bit LDR/STR word accesses onto a 16-bit SRAM as two half-word cycles
// with programmable wait states; ready stalls the pipeline while an access runs.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_r_en,
    input  logic                 mem_w_en,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ready,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [SRAM_DQ_W-1:0] sram_dq_out,
    output logic                 sram_dq_oe,
    input  logic [SRAM_DQ_W-1:0] sram_dq_in,
    output logic                 sram_we_n,
    output logic [1:0]           dbg_state
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_e               state_q, state_d;
    logic                 op_write_q, op_write_d;
    logic [SRAM_DQ_W-1:0] wdata_hi_q, wdata_hi_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic [SRAM_DQ_W-1:0] dq_out_q, dq_out_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 we_n_q, we_n_d;

    logic        req;
    logic        cnt_load;
    logic        cnt_expire;
    logic [31:0] offset;

    assign req    = mem_r_en | mem_w_en;
    assign offset = addr - BASE_ADDR;

    sram_wait_counter u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .expire   (cnt_expire)
    );

    // Pad controls are registered from the next state, so they switch together
    // with the state and stay stable for the whole half.
    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        wdata_hi_d  = wdata_hi_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        cnt_load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_LO;
                    cnt_load    = 1'b1;
                    // A simultaneous read and write request is served as a read.
                    op_write_d  = mem_w_en & ~mem_r_en;
                    wdata_hi_d  = wdata[31:16];
                    sram_addr_d = {offset[SRAM_AW:2], 1'b0};
                    dq_out_d    = wdata[15:0];
                    dq_oe_d     = op_write_d;
                    we_n_d      = ~op_write_d;
                end
            end
            ST_LO: begin
                dq_oe_d = op_write_q;
                we_n_d  = ~op_write_q;
                if (cnt_expire) begin
                    state_d        = ST_HI;
                    cnt_load       = 1'b1;
                    sram_addr_d[0] = 1'b1;
                    dq_out_d       = wdata_hi_q;
                    if (!op_write_q) begin
                        rdata_d = {rdata_q[31:16], sram_dq_in};
                    end
                end
            end
            ST_HI: begin
                dq_oe_d = op_write_q;
                we_n_d  = ~op_write_q;
                if (cnt_expire) begin
                    state_d = ST_DONE;
                    dq_oe_d = 1'b0;
                    we_n_d  = 1'b1;
                    if (!op_write_q) begin
                        rdata_d = {sram_dq_in, rdata_q[15:0]};
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_write_q  <= 1'b0;
            wdata_hi_q  <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            wdata_hi_q  <= wdata_hi_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready       = ((state_q == ST_IDLE) & ~mem_r_en & ~mem_w_en) | (state_q == ST_DONE);
    assign rdata       = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with an SRAM model and write/read scoreboards.
module tb_mem_stage_sram_ctrl;
    import mem_stage_sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_r_en, mem_w_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;
    logic [1:0]  dbg_state;

    logic        r1, w1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] dq_out1, dq_in1;
    logic        oe1, we_n1;
    logic [1:0]  dbg1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t         exp_w_q[$];
    logic [31:0] exp_r_q[$];

    logic [15:0] sram_mem [0:255];
    logic        mon_en = 1'b0;
    logic        we_low_seen = 1'b0;
    logic        last_we_n = 1'b1;
    logic [17:0] last_a = '0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .dbg_state(dbg_state)
    );

    mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_r_en(r1), .mem_w_en(w1),
        .addr(addr1), .wdata(wdata1), .rdata(rdata1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_oe(oe1),
        .sram_dq_in(dq_in1), .sram_we_n(we_n1), .dbg_state(dbg1)
    );

    // SRAM models: dut writes into a small array, dut1 reads an address-derived pattern.
    always @(posedge clk) begin
        if (rst_n && !sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq_out;
    end
    assign sram_dq_in = sram_mem[sram_addr[7:0]];
    assign dq_in1     = 16'hC000 | 16'(sram_addr1);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write monitor: each new half (strobe falling or address change) pops one expected write.
    always @(negedge clk) begin
        if (rst_n && !sram_we_n) begin
            we_low_seen = 1'b1;
            if (mon_en && (last_we_n || sram_addr != last_a)) begin
                chk("wr_oe", {63'd0, sram_dq_oe}, 64'd1);
                if (exp_w_q.size() == 0) begin
                    chk("wr_unexpected", {30'd0, sram_addr, sram_dq_out}, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_w_q.pop_front();
                    chk("wr_half", {30'd0, sram_addr, sram_dq_out}, {30'd0, e.a, e.d});
                end
            end
        end
        last_we_n = sram_we_n;
        last_a    = sram_addr;
    end

    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input int exp_stall, input bit glitch);
        int          cyc;
        logic [31:0] wd;
        logic [17:0] ha;
        wd = (a - 32'd1024) >> 2;
        ha = {wd[16:0], 1'b0};
        mem_r_en = r; mem_w_en = w; addr = a; wdata = d;
        if (r) exp_r_q.push_back(exp_rd);
        else if (w) begin
            exp_w_q.push_back('{a: ha,         d: d[15:0]});
            exp_w_q.push_back('{a: ha | 18'd1, d: d[31:16]});
        end
        #1;
        chk("ready_req_cycle", {63'd0, ready}, 64'd0);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) chk("state_lo_after_req", {62'd0, dbg_state}, {62'd0, ST_LO});
            if (glitch && cyc == 2) begin
                mem_r_en = ~r; mem_w_en = ~w; addr = 32'd2000; wdata = 32'h0;
            end
        end
        chk("stall_cycles", 64'(cyc), 64'(exp_stall));
        chk("state_done", {62'd0, dbg_state}, {62'd0, ST_DONE});
        if (r) begin
            if (exp_r_q.size() == 0) chk("rd_queue_empty", 64'd1, 64'd0);
            else chk("rdata_done", {32'd0, rdata}, {32'd0, exp_r_q.pop_front()});
        end
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [31:0] ra, rd;
        rst_n = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0;
        r1 = 1'b0; w1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we_n", {63'd0, sram_we_n}, 64'd1);
        chk("rst_oe", {63'd0, sram_dq_oe}, 64'd0);
        chk("rst_addr", {46'd0, sram_addr}, 64'd0);
        chk("rst_dq_out", {48'd0, sram_dq_out}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", {63'd0, ready}, 64'd1);

        // Reset asserted in the middle of a write.
        @(posedge clk); #1;
        mem_w_en = 1'b1; addr = 32'd1032; wdata = 32'h11112222;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_we_low", {63'd0, sram_we_n}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_we_n", {63'd0, sram_we_n}, 64'd1);
        chk("abort_oe", {63'd0, sram_dq_oe}, 64'd0);
        mem_w_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort_ready", {63'd0, ready}, 64'd1);
        chk("abort_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        mon_en = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, '0, 5, 1'b0);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, 5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rdata_held", {32'd0, rdata}, {32'd0, 32'hDEADBEEF});

        // LDR followed directly by STR.
        access(1'b0, 1'b1, 32'd1040, 32'h12345678, '0, 5, 1'b0);
        access(1'b1, 1'b0, 32'd1040, 32'h0, 32'h12345678, 5, 1'b0);
        access(1'b0, 1'b1, 32'd1044, 32'hCAFEF00D, '0, 5, 1'b0);
        chk("rdata_after_str", {32'd0, rdata}, {32'd0, 32'h12345678});

        // Both enables high reads and never strobes.
        access(1'b0, 1'b1, 32'd1024, 32'h22221111, '0, 5, 1'b0);
        we_low_seen = 1'b0;
        access(1'b1, 1'b1, 32'd1024, 32'hFFFFFFFF, 32'h22221111, 5, 1'b0);
        chk("both_en_no_write", {63'd0, we_low_seen}, 64'd0);

        // Inputs change mid-access; latched STR must complete unchanged.
        access(1'b0, 1'b1, 32'd1048, 32'hA5A55A5A, '0, 5, 1'b1);
        chk("rdata_after_glitch", {32'd0, rdata}, {32'd0, 32'h22221111});
        access(1'b1, 1'b0, 32'd1048, 32'h0, 32'hA5A55A5A, 5, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ra = 32'd1024 + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
            rd = $urandom;
            access(1'b0, 1'b1, ra, rd, '0, 5, 1'b0);
            access(1'b1, 1'b0, ra, 32'h0, rd, 5, 1'b0);
        end

        // WAIT_CYCLES=1 instance: 3-cycle stall.
        r1 = 1'b1; addr1 = 32'd1032;
        #1;
        cyc = 0;
        while (ready1 !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("w1_stall_cycles", 64'(cyc), 64'd3);
        chk("w1_rdata", {32'd0, rdata1}, {32'd0, 32'hC005C004});
        @(posedge clk); #1;
        r1 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("wr_queue_drained", 64'(exp_w_q.size()), 64'd0);
        chk("rd_queue_drained", 64'(exp_r_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
